ddr3_traffic_generator: RTL and testbench

DDR3_TRAFFIC_GENERATOR -- requirements
Module: ddr3_traffic_generator

---
 rtl/ddr3_test_pkg.sv | 20 ++
 rtl/ddr3_traffic_generator.sv | 119 +++++++++++
 tb/tb_ddr3_traffic_generator.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_test_pkg.sv
// Shared types and the write-data pattern used by the DDR3 traffic generator
// and by any read-data checker that verifies the returned words.
package ddr3_test_pkg;

  localparam logic [63:0] PATTERN_BASE = 64'hdeadfadebabebeef;

  typedef enum logic [2:0] {
    WAIT_FOR_INIT = 3'd0,
    WRITE         = 3'd1,
    READ          = 3'd2,
    DRAIN         = 3'd3,
    FINISHED      = 3'd4,
    ERROR         = 3'd5
  } state_t;

  function automatic logic [63:0] pattern(input logic [63:0] idx);
    return PATTERN_BASE ^ idx;
  endfunction

endpackage

// File: rtl/ddr3_traffic_generator.sv
// Writes a known pattern to every word of a DDR3 region, then reads every word
// back with a bounded number of reads in flight, and reports completion/failure.
module ddr3_traffic_generator
  import ddr3_test_pkg::*;
#(
  parameter int unsigned WORDS_LOG2      = 24,
  parameter int unsigned MAX_OUTSTANDING = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ddr3_init_done,
  input  logic                  ddr3_cal_success,
  input  logic                  ddr3_cal_fail,
  input  logic                  avl_ready,
  input  logic                  avl_rdata_valid,
  output logic                  avl_write_req,
  output logic                  avl_read_req,
  output logic                  avl_burstbegin,
  output logic [2:0]            avl_size,
  output logic [WORDS_LOG2-1:0] avl_addr,
  output logic [63:0]           avl_wdata,
  output logic [7:0]            avl_be,
  output logic                  is_finished,
  output logic                  fail
);

  localparam int unsigned CNT_W = WORDS_LOG2 + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = {1'b0, {WORDS_LOG2{1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MAX   = OUT_W'(MAX_OUTSTANDING);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [OUT_W-1:0] r_outst;
  logic [OUT_W-1:0] w_outst_next;
  logic             r_is_finished;
  logic             r_fail;
  logic             w_rd_xfer;
  logic             w_ret;

  // State, counters and sticky status flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= WAIT_FOR_INIT;
      r_cnt         <= '0;
      r_outst       <= '0;
      r_is_finished <= 1'b0;
      r_fail        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_outst <= w_outst_next;
      if (r_state == FINISHED || r_state == ERROR) r_is_finished <= 1'b1;
      if (r_state == ERROR) r_fail <= 1'b1;
    end
  end

  // Next-state, counter updates and Moore request outputs.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_outst_next  = r_outst;
    w_rd_xfer     = 1'b0;
    avl_write_req = 1'b0;
    avl_read_req  = 1'b0;
    avl_addr      = '0;
    avl_wdata     = '0;
    w_ret         = avl_rdata_valid && (r_outst != '0);

    case (r_state)
      WAIT_FOR_INIT: begin
        if (ddr3_init_done) begin
          if (ddr3_cal_success)   w_state_next = WRITE;
          else if (ddr3_cal_fail) w_state_next = ERROR;
        end
      end
      WRITE: begin
        avl_write_req = 1'b1;
        avl_addr      = r_cnt[WORDS_LOG2-1:0];
        avl_wdata     = pattern(64'(r_cnt));
        if (avl_ready) begin
          if (r_cnt == LAST_WORD) begin
            w_cnt_next   = '0;
            w_state_next = READ;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
      end
      READ: begin
        avl_read_req = (r_outst != OUT_MAX);
        avl_addr     = r_cnt[WORDS_LOG2-1:0];
        w_rd_xfer    = avl_read_req && avl_ready;
        if (w_rd_xfer) begin
          w_cnt_next = r_cnt + CNT_W'(1);
          if (r_cnt == LAST_WORD) w_state_next = DRAIN;
        end
      end
      DRAIN, FINISHED, ERROR: begin
      end
      default: w_state_next = WAIT_FOR_INIT;
    endcase

    // A return with nothing in flight is spurious and does not count.
    if (w_rd_xfer && !w_ret)      w_outst_next = r_outst + OUT_W'(1);
    else if (!w_rd_xfer && w_ret) w_outst_next = r_outst - OUT_W'(1);

    if (r_state == DRAIN && w_outst_next == '0) w_state_next = FINISHED;
  end

  assign avl_burstbegin = avl_write_req | avl_read_req;
  assign avl_size       = 3'd1;
  assign avl_be         = 8'hff;
  assign is_finished    = r_is_finished;
  assign fail           = r_fail;

endmodule

// File: tb/tb_ddr3_traffic_generator.sv
// Randomized bench for ddr3_traffic_generator: a transaction-count model predicts
// every request, address and data word, and the finish/fail flags, each cycle.
module tb_ddr3_traffic_generator;

  localparam logic [63:0] BASE = 64'hdeadfadebabebeef;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic init_done = 1'b0, cal_success = 1'b0, cal_fail = 1'b0;
  logic avl_ready = 1'b0, avl_rdata_valid = 1'b0;

  logic        wr0, rd0, bb0, fin0, fail0;
  logic [2:0]  size0;
  logic [3:0]  addr0;
  logic [63:0] wdata0;
  logic [7:0]  be0;
  logic        wr1, rd1, bb1, fin1, fail1;
  logic [2:0]  size1;
  logic [0:0]  addr1;
  logic [63:0] wdata1;
  logic [7:0]  be1;
  logic        rst_n0, rst_n1;

  always #5 clk = ~clk;

  // Only the selected instance is out of reset; the other is parked.
  assign rst_n0 = sel ? 1'b0 : rst_n;
  assign rst_n1 = sel ? rst_n : 1'b0;

  ddr3_traffic_generator #(.WORDS_LOG2(4), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset_n(rst_n0), .ddr3_init_done(init_done),
    .ddr3_cal_success(cal_success), .ddr3_cal_fail(cal_fail),
    .avl_ready(avl_ready), .avl_rdata_valid(avl_rdata_valid),
    .avl_write_req(wr0), .avl_read_req(rd0), .avl_burstbegin(bb0),
    .avl_size(size0), .avl_addr(addr0), .avl_wdata(wdata0), .avl_be(be0),
    .is_finished(fin0), .fail(fail0)
  );

  ddr3_traffic_generator #(.WORDS_LOG2(1), .MAX_OUTSTANDING(MAXO)) dut_w1 (
    .clk(clk), .reset_n(rst_n1), .ddr3_init_done(init_done),
    .ddr3_cal_success(cal_success), .ddr3_cal_fail(cal_fail),
    .avl_ready(avl_ready), .avl_rdata_valid(avl_rdata_valid),
    .avl_write_req(wr1), .avl_read_req(rd1), .avl_burstbegin(bb1),
    .avl_size(size1), .avl_addr(addr1), .avl_wdata(wdata1), .avl_be(be1),
    .is_finished(fin1), .fail(fail1)
  );

  logic        o_wr, o_rd, o_bb, o_fin, o_fail;
  logic [2:0]  o_size;
  logic [3:0]  o_addr;
  logic [63:0] o_wdata;
  logic [7:0]  o_be;
  assign o_wr    = sel ? wr1    : wr0;
  assign o_rd    = sel ? rd1    : rd0;
  assign o_bb    = sel ? bb1    : bb0;
  assign o_fin   = sel ? fin1   : fin0;
  assign o_fail  = sel ? fail1  : fail0;
  assign o_size  = sel ? size1  : size0;
  assign o_addr  = sel ? {3'b000, addr1} : addr0;
  assign o_wdata = sel ? wdata1 : wdata0;
  assign o_be    = sel ? be1    : be0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Accepted transfers as seen on the bus.
  int mon_wr = 0, mon_rd = 0;
  always @(posedge clk) begin
    if (rst_n && avl_ready) begin
      if (o_wr) mon_wr <= mon_wr + 1;
      if (o_rd) mon_rd <= mon_rd + 1;
    end
  end

  // Reference model: progress measured in accepted writes/reads and reads in flight.
  bit m_started, m_err, e_wr, e_rd, last_rdx;
  int m_wr, m_rd, m_outst, m_end;

  function automatic int words();
    return sel ? 2 : 16;
  endfunction

  task automatic model_reset();
    m_started = 0; m_err = 0; m_wr = 0; m_rd = 0; m_outst = 0; m_end = 0;
    last_rdx = 0; e_wr = 0; e_rd = 0;
  endtask

  task automatic check_outputs();
    int n;
    logic [3:0] ea;
    logic [63:0] ed;
    bit ended;
    n  = words();
    e_wr = m_started && (m_wr < n);
    e_rd = m_started && (m_wr == n) && (m_rd < n) && (m_outst < MAXO);
    ea = 4'd0;
    ed = 64'd0;
    if (e_wr) begin
      ea = 4'(m_wr);
      ed = BASE ^ 64'(m_wr);
    end else if (m_started && m_wr == n && m_rd < n) begin
      ea = 4'(m_rd);
    end
    ended = m_err || (m_started && m_wr == n && m_rd == n && m_outst == 0);
    if (ended) m_end++;
    check("req", 64'({o_bb, o_wr, o_rd}), 64'({e_wr | e_rd, e_wr, e_rd}));
    check("addr", 64'(o_addr), 64'(ea));
    check("wdata", o_wdata, ed);
    check("size_be", 64'({o_size, o_be}), 64'({3'd1, 8'hff}));
    if (m_end != 1) begin
      check("is_finished", 64'(o_fin), 64'(m_end >= 2));
      check("fail", 64'(o_fail), 64'(m_err && m_end >= 2));
    end
  endtask

  task automatic model_update();
    bit wx, rx, ret;
    last_rdx = 0;
    if (!rst_n) begin
      model_reset();
    end else if (!m_started && !m_err) begin
      if (init_done && cal_success)   m_started = 1;
      else if (init_done && cal_fail) m_err = 1;
    end else if (m_started) begin
      wx  = e_wr && avl_ready;
      rx  = e_rd && avl_ready;
      ret = avl_rdata_valid && (m_outst > 0);
      if (wx) m_wr++;
      if (rx) m_rd++;
      m_outst = m_outst + int'(rx) - int'(ret);
      last_rdx = rx;
    end
  endtask

  task automatic cycle(input bit rs, input bit ini, input bit suc, input bit cf,
                       input bit rdy, input bit vld);
    @(negedge clk);
    check_outputs();
    rst_n = rs; init_done = ini; cal_success = suc; cal_fail = cf;
    avl_ready = rdy; avl_rdata_valid = vld;
    model_update();
  endtask

  // mode 0: always ready, one-cycle read latency; 1: random ready/valid;
  // 2: always ready, returns withheld, then one pulse, then continuous.
  task automatic run(input int mode, input int rst_at, input bit cf_mode, input string name);
    int c0w, c0r, cyc, rdc, n, extra;
    bit did_rst, r, v, rs;
    c0w = mon_wr; c0r = mon_rd; cyc = 0; rdc = 0; did_rst = 0;
    n = words();
    cycle(0, 0, 0, 0, 0, 0);
    repeat (2) cycle(1, 0, 0, 0, 1, 0);
    while (m_end < 5 && cyc < 3000) begin
      rs = 1; r = 1; v = 0;
      case (mode)
        0: v = last_rdx;
        1: begin
          r = 1'($urandom_range(0, 1));
          v = (m_outst > 0 || m_wr < n) && ($urandom_range(0, 2) == 0);
        end
        default: begin
          if (m_wr == n) rdc++;
          v = (m_outst > 0) && (rdc == 12 || rdc > 24);
        end
      endcase
      if (rst_at >= 0 && !did_rst && m_started && m_wr == rst_at) begin
        rs = 0;
        did_rst = 1;
      end
      cycle(rs, 1, !cf_mode, cf_mode, r, v);
      cyc++;
    end
    check({name, "_timeout"}, 64'(cyc < 3000), 64'd1);
    @(negedge clk);
    extra = did_rst ? rst_at : 0;
    check({name, "_nwr"}, 64'(mon_wr - c0w), cf_mode ? 64'd0 : 64'(n + extra));
    check({name, "_nrd"}, 64'(mon_rd - c0r), cf_mode ? 64'd0 : 64'(n));
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    run(0, -1, 0, "basic");
    run(0, -1, 1, "calfail");
    run(1, -1, 0, "random_a");
    run(1, -1, 0, "random_b");
    run(2, -1, 0, "backpressure");
    run(0, 7, 0, "midreset");
    @(negedge clk);
    rst_n = 1'b0;
    sel = 1'b1;
    model_reset();
    run(0, -1, 0, "w1_basic");
    run(1, -1, 0, "w1_random");
    run(2, -1, 0, "w1_backpressure");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
